// File: rtl/alu_arb_pkg.sv
// Shared definitions for the ALU arbiter: opcodes, FIFO depth and response entry layout.
package alu_arb_pkg;

  localparam logic [2:0] OP_NOP = 3'b000;
  localparam logic [2:0] OP_ADD = 3'b001;
  localparam logic [2:0] OP_AND = 3'b010;
  localparam logic [2:0] OP_OR  = 3'b011;

  localparam int unsigned RESP_DEPTH_DEF = 2;

  // Wide enough to tag up to eight requesters; narrower tags are derived at the port.
  localparam int unsigned MAX_ID_W = 3;

  typedef struct packed {
    logic [31:0]         data;
    logic [MAX_ID_W-1:0] id;
  } resp_entry_t;

endpackage

// File: rtl/alu_arbiter_rr_arbiter.sv
// Round-robin grant over a request vector; the pointer moves past the winner on each grant.
module rr_arbiter #(
  parameter int unsigned NUM_REQ = 4,
  localparam int unsigned IdxW = $clog2(NUM_REQ)
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               en_i,
  input  logic [NUM_REQ-1:0] req_i,
  output logic [NUM_REQ-1:0] gnt_o,
  output logic [IdxW-1:0]    idx_o
);

  logic [IdxW-1:0] ptr_q;
  logic [IdxW-1:0] cand;
  logic            found;

  // Search upward from the pointer, wrapping at NUM_REQ; first valid request wins.
  always_comb begin
    gnt_o = '0;
    idx_o = '0;
    found = 1'b0;
    cand  = '0;
    for (int unsigned k = 0; k < NUM_REQ; k++) begin
      cand = IdxW'((32'(ptr_q) + k) % NUM_REQ);
      if (en_i && !found && req_i[cand]) begin
        found       = 1'b1;
        gnt_o[cand] = 1'b1;
        idx_o       = cand;
      end
    end
  end

  // Pointer advances to the slot after the winner; holds when nothing is granted.
  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      ptr_q <= '0;
    end else if (found) begin
      ptr_q <= (idx_o == IdxW'(NUM_REQ - 1)) ? '0 : idx_o + 1'b1;
    end
  end

endmodule

// File: rtl/alu_arbiter.sv
// Shares one registered-input ALU among NUM_REQ requesters and returns tagged results
// through a two-entry response FIFO.
module alu_arbiter
  import alu_arb_pkg::*;
#(
  parameter int unsigned NUM_REQ    = 4,
  parameter int unsigned ID_W       = 2,
  parameter int unsigned RESP_DEPTH = RESP_DEPTH_DEF
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [NUM_REQ-1:0]   req_valid,
  output logic [NUM_REQ-1:0]   req_ready,
  input  logic [32*NUM_REQ-1:0] req_a,
  input  logic [32*NUM_REQ-1:0] req_b,
  input  logic [3*NUM_REQ-1:0] req_op,
  output logic [31:0]          alu_a,
  output logic [31:0]          alu_b,
  output logic [2:0]           alu_op,
  input  logic [31:0]          alu_out,
  output logic                 resp_valid,
  input  logic                 resp_ready,
  output logic [31:0]          resp_data,
  output logic [ID_W-1:0]      resp_id,
  output logic                 busy
);

  localparam int unsigned IdxW = $clog2(NUM_REQ);

  logic                inflight_q;
  logic [MAX_ID_W-1:0] tag_q;
  resp_entry_t         mem_q [2];
  logic                wr_ptr_q;
  logic                rd_ptr_q;
  logic [1:0]          count_q;

  logic                issue_en;
  logic                hs;
  logic                push;
  logic                pop;
  logic [IdxW-1:0]     win_idx;

  // Conservative credit: a same-cycle pop does not free a slot for issue.
  assign issue_en = !reset && ((3'(inflight_q) + 3'(count_q)) < 3'(RESP_DEPTH));

  rr_arbiter #(
    .NUM_REQ(NUM_REQ)
  ) u_rr (
    .clk_i  (clk),
    .reset_i(reset),
    .en_i   (issue_en),
    .req_i  (req_valid),
    .gnt_o  (req_ready),
    .idx_o  (win_idx)
  );

  // Grants only go to valid requesters, so any grant bit is a handshake.
  assign hs = |req_ready;

  // Route the winner's operands to the ALU; idle cycles present a NOP.
  always_comb begin
    alu_a  = '0;
    alu_b  = '0;
    alu_op = OP_NOP;
    if (hs) begin
      alu_a  = req_a[win_idx*32 +: 32];
      alu_b  = req_b[win_idx*32 +: 32];
      alu_op = req_op[win_idx*3 +: 3];
    end
  end

  // Track the single operation whose result appears on alu_out next cycle.
  always_ff @(posedge clk) begin
    if (reset) begin
      inflight_q <= 1'b0;
      tag_q      <= '0;
    end else begin
      inflight_q <= hs;
      if (hs) begin
        tag_q <= MAX_ID_W'(win_idx);
      end
    end
  end

  assign push       = inflight_q;
  assign resp_valid = (count_q != 2'd0);
  assign pop        = resp_valid && resp_ready;
  assign resp_data  = mem_q[rd_ptr_q].data;
  assign resp_id    = ID_W'(mem_q[rd_ptr_q].id);
  assign busy       = inflight_q || (count_q != 2'd0);

  // Two-entry response FIFO; reset drops any buffered results.
  always_ff @(posedge clk) begin
    if (reset) begin
      mem_q[0] <= '0;
      mem_q[1] <= '0;
      wr_ptr_q <= 1'b0;
      rd_ptr_q <= 1'b0;
      count_q  <= 2'd0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= '{data: alu_out, id: tag_q};
        wr_ptr_q        <= ~wr_ptr_q;
      end
      if (pop) begin
        rd_ptr_q <= ~rd_ptr_q;
      end
      unique case ({push, pop})
        2'b10:   count_q <= count_q + 2'd1;
        2'b01:   count_q <= count_q - 2'd1;
        default: count_q <= count_q;
      endcase
    end
  end

  full_push_a: assert property (@(posedge clk) disable iff (reset) !(push && count_q == 2'd2));

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a behavioural registered-input ALU.
module tb_alu_arbiter;
  import alu_arb_pkg::*;

  localparam int unsigned N  = 4;
  localparam int unsigned IW = 2;

  logic              clk = 1'b0;
  logic              reset;
  logic [N-1:0]      req_valid;
  logic [N-1:0]      req_ready;
  logic [32*N-1:0]   req_a;
  logic [32*N-1:0]   req_b;
  logic [3*N-1:0]    req_op;
  logic [31:0]       alu_a;
  logic [31:0]       alu_b;
  logic [2:0]        alu_op;
  logic [31:0]       alu_out;
  logic              resp_valid;
  logic              resp_ready;
  logic [31:0]       resp_data;
  logic [IW-1:0]     resp_id;
  logic              busy;

  always #5 clk = ~clk;

  alu_arbiter #(
    .NUM_REQ   (N),
    .ID_W      (IW),
    .RESP_DEPTH(2)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .req_valid (req_valid),
    .req_ready (req_ready),
    .req_a     (req_a),
    .req_b     (req_b),
    .req_op    (req_op),
    .alu_a     (alu_a),
    .alu_b     (alu_b),
    .alu_op    (alu_op),
    .alu_out   (alu_out),
    .resp_valid(resp_valid),
    .resp_ready(resp_ready),
    .resp_data (resp_data),
    .resp_id   (resp_id),
    .busy      (busy)
  );

  // ALU model: operands captured on the edge, result combinational from the captures.
  logic [31:0] ra = '0;
  logic [31:0] rb = '0;
  logic [2:0]  rop = '0;
  always @(posedge clk) begin
    ra  <= alu_a;
    rb  <= alu_b;
    rop <= alu_op;
  end
  always_comb begin
    case (rop)
      OP_ADD:  alu_out = ra + rb;
      OP_AND:  alu_out = ra & rb;
      OP_OR:   alu_out = ra | rb;
      default: alu_out = '0;
    endcase
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", tag, obs, exp);
    end
  endtask

  // Handshakes observed mid-cycle, i.e. exactly those the next edge will commit.
  int              grant_q [$];
  logic [IW+31:0]  resp_q  [$];
  int              exp_g   [$];
  logic [IW+31:0]  exp_r   [$];

  always @(negedge clk) begin
    if (reset === 1'b0) begin
      for (int i = 0; i < N; i++) begin
        if (req_valid[i] && req_ready[i]) grant_q.push_back(i);
      end
      if (resp_valid && resp_ready) resp_q.push_back({resp_id, resp_data});
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_req(input int i, input logic [31:0] a, input logic [31:0] b,
                         input logic [2:0] op);
    req_a[32*i +: 32] = a;
    req_b[32*i +: 32] = b;
    req_op[3*i +: 3]  = op;
  endtask

  task automatic apply_reset();
    req_valid = '0;
    reset     = 1'b1;
    tick();
    reset = 1'b0;
    grant_q.delete();
    resp_q.delete();
    exp_g.delete();
    exp_r.delete();
  endtask

  task automatic wait_grants(input int n, input string tag);
    int c = 0;
    while (grant_q.size() < n && c < 50) begin
      tick();
      c++;
    end
    check_eq({tag, " grant count"}, 32'(grant_q.size()), 32'(n));
  endtask

  task automatic wait_idle(input string tag);
    int c = 0;
    while (busy && c < 50) begin
      tick();
      c++;
    end
    check_eq({tag, " idle"}, 32'(busy), 32'd0);
  endtask

  task automatic compare_grants(input string tag);
    for (int k = 0; k < exp_g.size(); k++) begin
      int g = (k < grant_q.size()) ? grant_q[k] : -1;
      check_eq($sformatf("%s grant%0d", tag, k), 32'(g), 32'(exp_g[k]));
    end
  endtask

  task automatic compare_resps(input string tag);
    check_eq({tag, " resp count"}, 32'(resp_q.size()), 32'(exp_r.size()));
    for (int k = 0; k < exp_r.size(); k++) begin
      logic [IW+31:0] r;
      r = (k < resp_q.size()) ? resp_q[k] : '1;
      check_eq($sformatf("%s resp%0d id", tag, k), 32'(r[IW+31:32]), 32'(exp_r[k][IW+31:32]));
      check_eq($sformatf("%s resp%0d data", tag, k), r[31:0], exp_r[k][31:0]);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    // Reset with every requester valid: nothing may leak through.
    reset      = 1'b1;
    resp_ready = 1'b1;
    req_a = '0; req_b = '0; req_op = '0;
    for (int i = 0; i < N; i++) set_req(i, 32'h1111_0000 + 32'(i), 32'h22, OP_ADD);
    req_valid = '1;
    tick();
    tick();
    check_eq("rst req_ready", 32'(req_ready), 32'd0);
    check_eq("rst alu_a", alu_a, 32'd0);
    check_eq("rst alu_b", alu_b, 32'd0);
    check_eq("rst alu_op", 32'(alu_op), 32'(OP_NOP));
    check_eq("rst resp_valid", 32'(resp_valid), 32'd0);
    check_eq("rst busy", 32'(busy), 32'd0);
    reset     = 1'b0;
    req_valid = '0;
    grant_q.delete();
    resp_q.delete();

    // Single request: 5 + 7 from requester 0, two cycles to response.
    set_req(0, 32'd5, 32'd7, OP_ADD);
    req_valid = 4'b0001;
    #1;
    check_eq("single req_ready", 32'(req_ready), 32'b0001);
    check_eq("single alu_a", alu_a, 32'd5);
    check_eq("single alu_b", alu_b, 32'd7);
    check_eq("single alu_op", 32'(alu_op), 32'(OP_ADD));
    tick();
    req_valid = '0;
    #1;
    check_eq("single t+1 resp_valid", 32'(resp_valid), 32'd0);
    check_eq("single t+1 busy", 32'(busy), 32'd1);
    check_eq("single t+1 alu_op", 32'(alu_op), 32'(OP_NOP));
    tick();
    check_eq("single t+2 resp_valid", 32'(resp_valid), 32'd1);
    check_eq("single t+2 resp_data", resp_data, 32'd12);
    check_eq("single t+2 resp_id", 32'(resp_id), 32'd0);
    tick();
    check_eq("single after resp_valid", 32'(resp_valid), 32'd0);
    check_eq("single after busy", 32'(busy), 32'd0);

    // All four requesters contending, pointer starting at 0.
    apply_reset();
    set_req(0, 32'd10, 32'd20, OP_ADD);
    set_req(1, 32'h0000_F0F0, 32'h0000_FF00, OP_AND);
    set_req(2, 32'h1, 32'h2, OP_OR);
    set_req(3, 32'hFFFF_FFFF, 32'h1, OP_ADD);
    resp_ready = 1'b1;
    req_valid  = 4'b1111;
    wait_grants(5, "rr");
    req_valid = '0;
    wait_idle("rr");
    exp_g = '{0, 1, 2, 3, 0};
    exp_r.push_back({2'd0, 32'd30});
    exp_r.push_back({2'd1, 32'h0000_F000});
    exp_r.push_back({2'd2, 32'h3});
    exp_r.push_back({2'd3, 32'h0});
    exp_r.push_back({2'd0, 32'd30});
    compare_grants("rr");
    compare_resps("rr");

    // Back-pressure: two results fill the FIFO and block further issue.
    apply_reset();
    set_req(0, 32'd100, 32'd23, OP_ADD);
    set_req(1, 32'hFFFF_0000, 32'h1234_5678, OP_AND);
    set_req(2, 32'd9, 32'd9, 3'b111);
    set_req(3, 32'h5, 32'hA, OP_OR);
    resp_ready = 1'b0;
    req_valid  = 4'b1111;
    wait_grants(2, "bp");
    tick();
    tick();
    check_eq("bp full req_ready", 32'(req_ready), 32'd0);
    check_eq("bp full resp_valid", 32'(resp_valid), 32'd1);
    check_eq("bp full busy", 32'(busy), 32'd1);
    check_eq("bp head data", resp_data, 32'd123);
    check_eq("bp head id", 32'(resp_id), 32'd0);
    resp_ready = 1'b1;
    wait_grants(3, "bp resume");
    req_valid = '0;
    wait_idle("bp");
    exp_g = '{0, 1, 2};
    exp_r.push_back({2'd0, 32'd123});
    exp_r.push_back({2'd1, 32'h1234_0000});
    exp_r.push_back({2'd2, 32'h0});
    compare_grants("bp");
    compare_resps("bp");

    // Reset while one result is buffered and another is in flight.
    apply_reset();
    resp_ready = 1'b0;
    set_req(0, 32'd1, 32'd1, OP_ADD);
    req_valid = 4'b0001;
    tick();
    tick();
    check_eq("mid pre busy", 32'(busy), 32'd1);
    check_eq("mid pre resp_valid", 32'(resp_valid), 32'd1);
    req_valid = '0;
    reset     = 1'b1;
    tick();
    reset = 1'b0;
    #1;
    check_eq("mid post resp_valid", 32'(resp_valid), 32'd0);
    check_eq("mid post busy", 32'(busy), 32'd0);
    resp_q.delete();
    resp_ready = 1'b1;
    repeat (6) tick();
    check_eq("mid stale resp", 32'(resp_q.size()), 32'd0);
    req_valid = 4'b1111;
    #1;
    check_eq("mid next grant", 32'(req_ready), 32'b0001);
    req_valid = '0;

    // Skewed: req2 alone moves the pointer to 3, so req1 beats req2 next.
    apply_reset();
    resp_ready = 1'b1;
    set_req(1, 32'd2, 32'd3, OP_ADD);
    set_req(2, 32'h10, 32'h01, OP_OR);
    req_valid = 4'b0100;
    #1;
    check_eq("skew first grant", 32'(req_ready), 32'b0100);
    tick();
    req_valid = 4'b0110;
    #1;
    check_eq("skew second grant", 32'(req_ready), 32'b0010);
    tick();
    req_valid = '0;
    wait_idle("skew");
    exp_r.push_back({2'd2, 32'h11});
    exp_r.push_back({2'd1, 32'd5});
    compare_resps("skew");

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule

// File: doc/alu_arbiter.md
Name: alu_arbiter

Overview:
- Shares one registered-input ALU (inputs captured on clk, result combinational from the captured registers, one-cycle latency) among NUM_REQ requesters.
- Round-robin arbitration over per-requester valid/ready request channels.
- Tracks the single in-flight operation and returns tagged results through a 2-entry response FIFO with valid/ready back-pressure.
- Sits between the requesting units and the ALU instance.

Parameters:
- NUM_REQ, 4, number of requesters (2..8).
- ID_W, 2, response tag width; must satisfy 2**ID_W >= NUM_REQ.
- RESP_DEPTH, 2, response FIFO entries; fixed at 2 for this revision.

Ports:
- clk  in  1  clock; all state updates on the rising edge.
- reset  in  1  synchronous, active-high reset.
- req_valid  in  NUM_REQ  per-requester request valid.
- req_ready  out  NUM_REQ  per-requester grant; at most one bit high.
- req_a  in  32*NUM_REQ  operand A; slice i belongs to requester i.
- req_b  in  32*NUM_REQ  operand B; slice i belongs to requester i.
- req_op  in  3*NUM_REQ  opcode; slice i belongs to requester i.
- alu_a  out  32  operand A to the ALU.
- alu_b  out  32  operand B to the ALU.
- alu_op  out  3  opcode to the ALU.
- alu_out  in  32  ALU result.
- resp_valid  out  1  response FIFO head valid.
- resp_ready  in  1  consumer accepts the response.
- resp_data  out  32  result at the FIFO head.
- resp_id  out  ID_W  index of the requester that issued the operation.
- busy  out  1  high when an operation is in flight or the FIFO is non-empty.

Behaviour:
- Reset: req_ready=0, alu_a=0, alu_b=0, alu_op=3'b000 (NOP), resp_valid=0, busy=0. The in-flight flag is cleared, FIFO count=0, and the round-robin pointer is set to 0.
- Reset mid-operation discards the in-flight result and all FIFO contents. Nothing is emitted after reset is released.
- Credit rule: issue is allowed in cycle t only if (inflight + fifo_count) < RESP_DEPTH. A resp_ready pop in the same cycle does NOT add credit; the check is conservative.
- Arbitration:
  - When issue is allowed, grant the first requester with req_valid=1, searching from rr_ptr upward and wrapping at NUM_REQ.
  - req_ready is combinational: one-hot on the winner, zero otherwise.
  - The handshake is req_valid[i] & req_ready[i].
  - On a handshake, rr_ptr becomes (winner+1) mod NUM_REQ. With no handshake, rr_ptr holds.
- ALU drive:
  - alu_a, alu_b and alu_op are combinational muxes of the winner's slice in the handshake cycle.
  - With no handshake, alu_op=3'b000, which makes the ALU produce 0. The arbiter never depends on that value.
- Latency:
  - A handshake in cycle t sets inflight=1 and tag=winner at edge t.
  - In cycle t+1, alu_out holds the result; at edge t+1 it is pushed into the FIFO with the tag.
  - resp_valid is high no earlier than cycle t+2.
  - Back-to-back issue is permitted whenever the credit rule allows it.
- FIFO:
  - First-in first-out; the head is presented on resp_data/resp_id.
  - Pop happens on resp_valid & resp_ready.
  - A push and a pop in the same cycle keep the count unchanged.
  - Overflow is impossible by the credit rule; a push with the FIFO full is an assertion failure.
- Opcodes are passed through unchecked. Undefined opcodes return 0 with a normal response.
- busy = inflight | (fifo_count != 0).
- Requesters must hold their operands stable while req_valid=1 and no grant has been received. The arbiter does not latch request data outside the handshake cycle.

Decomposition:
- Package alu_arb_pkg holds:
  - ALU opcode constants: OP_NOP=3'b000, OP_ADD=3'b001, OP_AND=3'b010, OP_OR=3'b011.
  - The default RESP_DEPTH.
  - A response-entry struct/typedef {data[31:0], id[ID_W-1:0]}.
- One sub-module, rr_arbiter: parameterized NUM_REQ round-robin grant from request vector and enable, with pointer update on accept.
- The FIFO stays inline, as two registers plus a count.

Test Plan:
- Single request, no contention: req0 issues a=5, b=7, op=001 with resp_ready=1 -> resp_valid two cycles after the handshake, resp_data=12, resp_id=0, busy then falls.
- All four requesters valid continuously, resp_ready=1, rr_ptr=0 -> grants 0,1,2,3,0. Responses tagged in that order; AND 0xF0F0 & 0xFF00 = 0xF000; OR 0x1 | 0x2 = 0x3.
- Back-pressure: resp_ready=0 with two requests issued -> FIFO full and req_ready=0 for all requesters. Release resp_ready -> both results pop in order and issue resumes.
- Wrap and overflow: a=0xFFFFFFFF, b=1, op=001 -> resp_data=0. Undefined op 3'b111 -> resp_data=0 with a valid response.
- Reset asserted for one cycle while an operation is in flight and the FIFO holds 1 entry -> resp_valid=0, busy=0, no stale response afterwards, and the next grant goes to requester 0.
- Skewed traffic: only req2 valid, then req1 valid -> req2 granted, rr_ptr=3. req1 is granted next only after searching 3, then wrapping to 0 and 1.
